// File: rtl/prog_mem_pkg.sv
// Shared types and default widths for the loadable program memory.
package prog_mem_pkg;

    // Default widths, matching the instruction ROM this block replaces
    localparam int unsigned WORD_SIZE_DEF = 16;
    localparam int unsigned ADDR_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2
    } state_e;

    // Index width for a word array; never zero, so a 1-word array still has a port
    function automatic int unsigned addr_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/prog_mem_array.sv
// DEPTH x WORD_SIZE storage: one write port, one registered read port, no reset.
module prog_mem_array
    import prog_mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
    parameter int unsigned DEPTH     = 128,
    localparam int unsigned AW       = addr_bits(DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic [WORD_SIZE-1:0] i_wdata,
    input  logic                 i_re,
    input  logic [AW-1:0]        i_raddr,
    output logic [WORD_SIZE-1:0] o_rdata
);

    logic [WORD_SIZE-1:0] r_mem [DEPTH];
    logic [WORD_SIZE-1:0] r_rdata;

    // Write on a load beat; read data registered only when a valid fetch asks for it
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_mem.sv
// Loadable program memory: boot-time image load over valid/ready, then
// byte-addressed, word-aligned fetches with one cycle of latency.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
    parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int unsigned DEPTH     = 2 ** (ADDR_SIZE - 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 boot_start,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [WORD_SIZE-1:0] load_data,
    input  logic                 load_last,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic                 rd_valid,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 rd_err,
    output logic                 running,
    output logic [ADDR_SIZE-1:0] prog_len,
    output logic                 load_ovf
);

    localparam int unsigned          AW       = addr_bits(DEPTH);
    localparam logic [ADDR_SIZE-1:0] DEPTH_A  = ADDR_SIZE'(DEPTH);
    localparam logic [AW-1:0]        LAST_PTR = AW'(DEPTH - 1);

    state_e               r_state, w_state_d;
    logic [AW-1:0]        r_ptr, w_ptr_d;
    logic [ADDR_SIZE-1:0] r_len, w_len_d;
    logic                 r_ovf, w_ovf_d;
    logic                 r_rd_valid, r_rd_err;

    logic                 w_beat;
    logic [ADDR_SIZE-1:0] w_word_addr;
    logic                 w_rd_bad;
    logic                 w_rd_ok;
    logic [WORD_SIZE-1:0] w_ram_rdata;

    assign w_beat      = (r_state == StLoad) && load_valid;
    assign w_word_addr = {1'b0, rd_addr[ADDR_SIZE-1:1]};
    assign w_rd_bad    = rd_addr[0] || (w_word_addr >= DEPTH_A) || (r_state != StRun);
    assign w_rd_ok     = rd_en && !w_rd_bad;

    // Next-state logic for the load FSM and its pointer/length/overflow bookkeeping
    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_len_d   = r_len;
        w_ovf_d   = r_ovf;
        unique case (r_state)
            StIdle, StRun: begin
                if (boot_start) begin
                    w_state_d = StLoad;
                    w_ptr_d   = '0;
                    w_len_d   = '0;
                    w_ovf_d   = 1'b0;
                end
            end
            StLoad: begin
                // boot_start is deliberately ignored here
                if (load_valid) begin
                    w_ptr_d = r_ptr + AW'(1);
                    w_len_d = r_len + ADDR_SIZE'(1);
                    if (load_last) begin
                        w_state_d = StRun;
                    end else if (r_ptr == LAST_PTR) begin
                        // Array full without an end marker: run what we have, flag it
                        w_state_d = StRun;
                        w_ovf_d   = 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // FSM and load bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_len   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_len   <= w_len_d;
            r_ovf   <= w_ovf_d;
        end
    end

    // Fetch response flags; the error is judged against the state at the request edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_err   <= rd_en && w_rd_bad;
        end
    end

    prog_mem_array #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_beat),
        .i_waddr (r_ptr),
        .i_wdata (load_data),
        .i_re    (w_rd_ok),
        .i_raddr (w_word_addr[AW-1:0]),
        .o_rdata (w_ram_rdata)
    );

    assign load_ready = (r_state == StLoad);
    assign running    = (r_state == StRun);
    assign prog_len   = r_len;
    assign load_ovf   = r_ovf;
    assign rd_valid   = r_rd_valid;
    assign rd_err     = r_rd_err;
    // The array output is unreset and holds stale data; only pass it on a good fetch
    assign rd_data    = (r_rd_valid && !r_rd_err) ? w_ram_rdata : '0;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: a default-size instance and a DEPTH=4 instance.
module tb_prog_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    // Default-size instance
    logic        boot_start, load_valid, load_last, rd_en;
    logic [15:0] load_data;
    logic [7:0]  rd_addr;
    logic        load_ready, rd_valid, rd_err, running, load_ovf;
    logic [15:0] rd_data;
    logic [7:0]  prog_len;

    // DEPTH=4 instance
    logic        boot_start4, load_valid4, load_last4, rd_en4;
    logic [15:0] load_data4;
    logic [7:0]  rd_addr4;
    logic        load_ready4, rd_valid4, rd_err4, running4, load_ovf4;
    logic [15:0] rd_data4;
    logic [7:0]  prog_len4;

    prog_mem u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .boot_start (boot_start),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .running    (running),
        .prog_len   (prog_len),
        .load_ovf   (load_ovf)
    );

    prog_mem #(
        .WORD_SIZE (16),
        .ADDR_SIZE (8),
        .DEPTH     (4)
    ) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .boot_start (boot_start4),
        .load_valid (load_valid4),
        .load_ready (load_ready4),
        .load_data  (load_data4),
        .load_last  (load_last4),
        .rd_en      (rd_en4),
        .rd_addr    (rd_addr4),
        .rd_valid   (rd_valid4),
        .rd_data    (rd_data4),
        .rd_err     (rd_err4),
        .running    (running4),
        .prog_len   (prog_len4),
        .load_ovf   (load_ovf4)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Expected fetch responses, {err, data}, pushed when the request is driven
    logic [16:0] q0[$];
    logic [16:0] q4[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fetch0(input logic [7:0] a, input logic [15:0] d, input logic e);
        rd_en   = 1'b1;
        rd_addr = a;
        q0.push_back({e, d});
    endtask

    task automatic fetch4(input logic [7:0] a, input logic [15:0] d, input logic e);
        rd_en4   = 1'b1;
        rd_addr4 = a;
        q4.push_back({e, d});
    endtask

    task automatic beat0(input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
    endtask

    task automatic beat4(input logic [15:0] d, input logic last);
        load_valid4 = 1'b1;
        load_data4  = d;
        load_last4  = last;
    endtask

    // One clock: consume driven inputs, check any fetch response, then idle the inputs
    task automatic cyc();
        logic        iss0, iss4;
        logic [16:0] e;
        iss0 = rd_en;
        iss4 = rd_en4;
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(iss0));
        chk("rd_valid4", 32'(rd_valid4), 32'(iss4));
        if (iss0) begin
            e = q0.pop_front();
            chk("rd_data", 32'(rd_data), 32'(e[15:0]));
            chk("rd_err", 32'(rd_err), 32'(e[16]));
        end
        if (iss4) begin
            e = q4.pop_front();
            chk("rd_data4", 32'(rd_data4), 32'(e[15:0]));
            chk("rd_err4", 32'(rd_err4), 32'(e[16]));
        end
        boot_start  = 1'b0;
        load_valid  = 1'b0;
        load_last   = 1'b0;
        rd_en       = 1'b0;
        boot_start4 = 1'b0;
        load_valid4 = 1'b0;
        load_last4  = 1'b0;
        rd_en4      = 1'b0;
    endtask

    task automatic reset_chk();
        chk("rst load_ready", 32'(load_ready), 32'(0));
        chk("rst rd_valid", 32'(rd_valid), 32'(0));
        chk("rst rd_data", 32'(rd_data), 32'(0));
        chk("rst rd_err", 32'(rd_err), 32'(0));
        chk("rst running", 32'(running), 32'(0));
        chk("rst prog_len", 32'(prog_len), 32'(0));
        chk("rst load_ovf", 32'(load_ovf), 32'(0));
        chk("rst load_ready4", 32'(load_ready4), 32'(0));
        chk("rst running4", 32'(running4), 32'(0));
    endtask

    logic [15:0] img [5];

    initial begin
        img[0] = 16'h0014;
        img[1] = 16'hF000;
        img[2] = 16'h0000;
        img[3] = 16'h0016;
        img[4] = 16'h01C2;

        rst_n       = 1'b0;
        boot_start  = 1'b0;
        load_valid  = 1'b0;
        load_last   = 1'b0;
        load_data   = '0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        boot_start4 = 1'b0;
        load_valid4 = 1'b0;
        load_last4  = 1'b0;
        load_data4  = '0;
        rd_en4      = 1'b0;
        rd_addr4    = '0;

        repeat (2) @(posedge clk);
        #1;
        reset_chk();
        rst_n = 1'b1;
        cyc();

        // Fetch while idle is refused
        fetch0(8'd0, 16'h0000, 1'b1);
        cyc();

        // Load a five-word image
        boot_start = 1'b1;
        cyc();
        chk("load_ready after boot", 32'(load_ready), 32'(1));
        for (int i = 0; i < 5; i++) begin
            beat0(img[i], i == 4);
            cyc();
            if (i < 4) chk("running mid-load", 32'(running), 32'(0));
        end
        chk("load_ready after last", 32'(load_ready), 32'(0));
        chk("running after last", 32'(running), 32'(1));
        chk("prog_len 5", 32'(prog_len), 32'(5));
        chk("load_ovf clean", 32'(load_ovf), 32'(0));

        fetch0(8'd0, 16'h0014, 1'b0);
        cyc();
        fetch0(8'd6, 16'h0016, 1'b0);
        cyc();
        fetch0(8'd8, 16'h01C2, 1'b0);
        cyc();
        fetch0(8'd3, 16'h0000, 1'b1);
        cyc();

        // Back-to-back fetches
        fetch0(8'd0, 16'h0014, 1'b0);
        cyc();
        fetch0(8'd2, 16'hF000, 1'b0);
        cyc();
        fetch0(8'd4, 16'h0000, 1'b0);
        cyc();
        fetch0(8'd6, 16'h0016, 1'b0);
        cyc();
        cyc();

        // Overflowing load into the 4-word instance
        boot_start4 = 1'b1;
        cyc();
        for (int i = 0; i < 6; i++) begin
            beat4(16'hA000 + 16'(i), 1'b0);
            cyc();
            if (i == 3) begin
                chk("ovf load_ready4", 32'(load_ready4), 32'(0));
                chk("ovf running4", 32'(running4), 32'(1));
                chk("ovf load_ovf4", 32'(load_ovf4), 32'(1));
            end
        end
        chk("ovf prog_len4", 32'(prog_len4), 32'(4));
        fetch4(8'd8, 16'h0000, 1'b1);
        cyc();
        fetch4(8'd6, 16'hA003, 1'b0);
        cyc();
        fetch4(8'd0, 16'hA000, 1'b0);
        cyc();

        // Reload request coinciding with a fetch: that fetch still served
        boot_start = 1'b1;
        fetch0(8'd2, 16'hF000, 1'b0);
        cyc();
        chk("reload load_ready", 32'(load_ready), 32'(1));
        chk("reload running", 32'(running), 32'(0));
        fetch0(8'd2, 16'h0000, 1'b1);
        cyc();

        // Two beats, then reset mid-load
        beat0(16'hAAAA, 1'b0);
        cyc();
        beat0(16'hBBBB, 1'b0);
        cyc();
        chk("prog_len 2", 32'(prog_len), 32'(2));
        rst_n = 1'b0;
        #1;
        reset_chk();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Reload three words; word 3 still holds the first image
        boot_start = 1'b1;
        cyc();
        beat0(16'h1111, 1'b0);
        cyc();
        beat0(16'h2222, 1'b0);
        cyc();
        beat0(16'h3333, 1'b1);
        cyc();
        chk("prog_len 3", 32'(prog_len), 32'(3));
        chk("running reload", 32'(running), 32'(1));
        fetch0(8'd0, 16'h1111, 1'b0);
        cyc();
        fetch0(8'd2, 16'h2222, 1'b0);
        cyc();
        fetch0(8'd4, 16'h3333, 1'b0);
        cyc();
        fetch0(8'd6, 16'h0016, 1'b0);
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prog_mem.md
# prog_mem

Parametrised, loadable program memory that succeeds the hard-coded instruction ROM. Software loads the program image word by word through a valid/ready port after reset. The memory then serves instruction and data fetches to the CPU with one-cycle registered latency. Addressing stays byte-based with word-aligned (even) addresses, so existing programs and jump targets are unchanged.

## Interface
Parameters:
- WORD_SIZE, default 16, instruction/data word width in bits
- ADDR_SIZE, default 8, byte-address width
- DEPTH, default 2**(ADDR_SIZE-1), number of words stored; must be ≤ 2**(ADDR_SIZE-1)

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- boot_start  in  1  one-cycle pulse that starts a program load
- load_valid  in  1  a load word is present
- load_ready  out  1  block accepts a load word this cycle
- load_data  in  WORD_SIZE  word to write
- load_last  in  1  marks the final word of the image
- rd_en  in  1  fetch request
- rd_addr  in  ADDR_SIZE  byte address of the fetch
- rd_valid  out  1  rd_data/rd_err are valid this cycle
- rd_data  out  WORD_SIZE  fetched word
- rd_err  out  1  fetch was misaligned, out of range, or issued while not running
- running  out  1  program is loaded and fetches are served
- prog_len  out  ADDR_SIZE  number of words written by the last load
- load_ovf  out  1  sticky flag: a load tried to go past DEPTH

## Operation
- FSM states: IDLE, LOAD, RUN. Reset enters IDLE.
- IDLE, on boot_start: go to LOAD, clear the write pointer and prog_len, clear load_ovf.
- LOAD behaviour:
  - load_ready=1.
  - Each beat (load_valid & load_ready) writes mem[ptr], increments ptr and increments prog_len.
  - A beat with load_last goes to RUN.
  - A beat that writes word DEPTH-1 without load_last goes to RUN and sets load_ovf.
- RUN: running=1. boot_start returns to LOAD (reload). Memory is only rewritten by beats.
- boot_start while in LOAD is ignored.
- Fetch: for rd_en in cycle N, rd_valid=1 in cycle N+1 with:
  - rd_addr[0]=1 gives rd_data=0, rd_err=1.
  - rd_addr>>1 ≥ DEPTH gives rd_data=0, rd_err=1.
  - state ≠ RUN at edge N gives rd_data=0, rd_err=1.
  - otherwise rd_data=mem[rd_addr>>1], rd_err=0.
- Fetches are fully pipelined: one accepted per cycle, no stall.
- Words never written read as their last written value. The array is not reset; the bench must not rely on array contents after power-up.

## Timing
- Reset values: load_ready=0, rd_valid=0, rd_data=0, rd_err=0, running=0, prog_len=0, load_ovf=0, state=IDLE, ptr=0.
- Reset asserted mid-load aborts the load to IDLE. Already-written words keep their contents.
- load_ready goes high the cycle after boot_start is sampled. It goes low the cycle after the final beat.
- running goes high the cycle after the final beat.
- Read-during-write cannot occur, because reads are served only in RUN and writes only in LOAD.
- boot_start and rd_en in the same RUN cycle: that fetch is served normally, because the state at that edge is RUN. Fetches from the next cycle return rd_err.
- rd_valid is a one-cycle pulse per request. It is low whenever rd_en was low the previous cycle.
- Latency: a load beat is visible to a fetch issued at least one cycle after running rises.

## Structure
- prog_mem_pkg holds:
  - the state typedef (IDLE/LOAD/RUN)
  - the default width constants, equal to the codebase's WORD_SIZE/ADDR_SIZE values
- Sub-module prog_mem_array: simple DEPTH×WORD_SIZE synchronous 1W1R RAM with registered read and no reset. The FSM, address checking and output registers sit in prog_mem.

## Test plan
- Reset, then boot_start, then load 16'h0014, 16'hF000, 16'h0000, 16'h0016, 16'h01C2 (last) → prog_len=5, running=1. Fetch addr 0 → 16'h0014, addr 6 → 16'h0016, addr 8 → 16'h01C2, each one cycle after rd_en.
- Fetch addr 0 in IDLE, and addr 3 in RUN → rd_valid=1, rd_data=0, rd_err=1.
- DEPTH=4, load 6 words without load_last → 4 accepted, load_ovf=1, running=1, load_ready=0 after the 4th beat. Addr 8 → rd_err=1.
- Back-to-back fetches at addrs 0,2,4,6 on consecutive cycles → four consecutive rd_valid pulses with the matching words.
- rst_n low after 2 load beats → all outputs at reset values, state IDLE. Reload of 3 words → prog_len=3.
- boot_start and rd_en(addr 2) in the same RUN cycle → fetch returns the loaded word with rd_err=0. A fetch the next cycle → rd_err=1.
